// File: rtl/fir_root.sv
// fir_root: seven-tap direct-form FIR with saturated 16-bit result and an
// eight-stage pipelined floor square root of that result.
module fir_root (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] Data_i,
    input  logic [7:0] B0,
    input  logic [7:0] B1,
    input  logic [7:0] B2,
    input  logic [7:0] B3,
    input  logic [7:0] B4,
    input  logic [7:0] B5,
    input  logic [7:0] B6,
    output logic [7:0] FIRout,
    output logic [7:0] ROOTout
);
    logic [7:0]  x [7];
    logic [7:0]  b [7];
    logic [18:0] sum;
    logic [15:0] q;
    logic [9:0]  rem_q [8], rem_i [8], rem_n [8];
    logic [7:0]  root_q [8], root_i [8], root_n [8];
    logic [15:0] rad_q [8], rad_i [8], rad_n [8];
    logic [11:0] acc [8], trial [8];
    logic        ge [8];
    assign b = '{B0, B1, B2, B3, B4, B5, B6};
    always_comb begin
        sum = '0;
        for (int k = 0; k < 7; k++)
            sum = sum + 19'(b[k]) * 19'(x[k]);
    end
    // Restoring recurrence: each stage brings down two radicand bits and
    // tries to append a 1 to the partial root.
    always_comb begin
        rem_i[0]  = '0;
        root_i[0] = '0;
        rad_i[0]  = q;
        for (int s = 1; s < 8; s++) begin
            rem_i[s]  = rem_q[s-1];
            root_i[s] = root_q[s-1];
            rad_i[s]  = rad_q[s-1];
        end
        for (int s = 0; s < 8; s++) begin
            acc[s]    = {rem_i[s], rad_i[s][15:14]};
            trial[s]  = {2'b00, root_i[s], 2'b01};
            ge[s]     = acc[s] >= trial[s];
            rem_n[s]  = 10'(ge[s] ? acc[s] - trial[s] : acc[s]);
            root_n[s] = (root_i[s] << 1) | 8'(ge[s]);
            rad_n[s]  = rad_i[s] << 2;
        end
    end
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 0; k < 7; k++) x[k] <= '0;
            q <= '0;
            for (int s = 0; s < 8; s++) begin
                rem_q[s]  <= '0;
                root_q[s] <= '0;
                rad_q[s]  <= '0;
            end
        end else begin
            x[0] <= Data_i;
            for (int k = 1; k < 7; k++) x[k] <= x[k-1];
            q <= sum > 19'd65535 ? 16'hFFFF : sum[15:0];
            for (int s = 0; s < 8; s++) begin
                rem_q[s]  <= rem_n[s];
                root_q[s] <= root_n[s];
                rad_q[s]  <= rad_n[s];
            end
        end
    end
    assign FIRout  = q[15:8];
    assign ROOTout = root_q[7];
endmodule

// File: tb/tb_fir_root.sv
// tb_fir_root: table-driven spec vectors plus a per-cycle reference model
// (sliding sample window, saturating sum, brute-force isqrt).
module tb_fir_root;
    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [7:0] Data_i;
    logic [7:0] coef [7];
    logic [7:0] FIRout, ROOTout;

    typedef struct {
        int data;
        int fir;
        int root;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   hist [7];
    int   qh [$];
    vec_t tab [$];

    fir_root dut (
        .Clk(Clk), .Rst_n(Rst_n), .Data_i(Data_i),
        .B0(coef[0]), .B1(coef[1]), .B2(coef[2]), .B3(coef[3]),
        .B4(coef[4]), .B5(coef[5]), .B6(coef[6]),
        .FIRout(FIRout), .ROOTout(ROOTout)
    );

    always #5 Clk = ~Clk;

    function automatic int sat_sum();
        int s = 0;
        for (int k = 0; k < 7; k++) s += int'(coef[k]) * hist[k];
        return s > 65535 ? 65535 : s;
    endfunction

    function automatic int isqrt(int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 7; k++) hist[k] = 0;
        qh = {};
        for (int i = 0; i < 9; i++) qh.push_back(0);
    endtask

    // One sample per clock; the model forms the sum from the window and
    // coefficients present just before the edge, exactly what gets registered.
    task automatic step(input int d);
        int qn;
        Data_i = 8'(d);
        qn = sat_sum();
        @(posedge Clk);
        for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = d;
        qh.push_front(qn);
        void'(qh.pop_back());
        #1;
        check("model_fir", int'(FIRout), qh[0] >> 8);
        check("model_root", int'(ROOTout), isqrt(qh[8]));
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        Data_i = 8'd0;
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_tab(string name);
        for (int i = 0; i < tab.size(); i++) begin
            step(tab[i].data);
            check({name, "_fir"}, int'(FIRout), tab[i].fir);
            check({name, "_root"}, int'(ROOTout), tab[i].root);
        end
    endtask

    initial begin
        int imp_fir [7]  = '{15, 31, 47, 63, 79, 95, 111};
        int imp_root [7] = '{63, 90, 110, 127, 142, 156, 168};
        int dc_root [7]  = '{4, 5, 6, 8, 8, 9, 10};

        // Reset held with clock running and full-scale input.
        Rst_n = 1'b0;
        Data_i = 8'd255;
        for (int k = 0; k < 7; k++) coef[k] = 8'd255;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #1;
            check("rst_fir", int'(FIRout), 0);
            check("rst_root", int'(ROOTout), 0);
        end
        Rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 12; i++) step(255);
        check("pre_drop_fir", int'(FIRout), 255);
        check("pre_drop_root", int'(ROOTout), 255);
        #2 Rst_n = 1'b0;
        #1;
        check("async_fir", int'(FIRout), 0);
        check("async_root", int'(ROOTout), 0);

        // Impulse response.
        for (int k = 0; k < 7; k++) coef[k] = 8'(16 * (k + 1));
        do_reset();
        tab = {};
        for (int i = 0; i < 17; i++)
            tab.push_back('{data: i == 0 ? 255 : 0,
                            fir: (i >= 1 && i <= 7) ? imp_fir[i-1] : 0,
                            root: (i >= 9 && i <= 15) ? imp_root[i-9] : 0});
        run_tab("impulse");

        // DC fill with unit coefficients.
        for (int k = 0; k < 7; k++) coef[k] = 8'd1;
        do_reset();
        tab = {};
        for (int i = 0; i < 18; i++)
            tab.push_back('{data: 16, fir: 0,
                            root: i < 9 ? 0 : (i <= 15 ? dc_root[i-9] : 10)});
        run_tab("dc");

        // Saturation and drain.
        for (int k = 0; k < 7; k++) coef[k] = 8'd255;
        do_reset();
        for (int i = 0; i < 16; i++) step(255);
        check("sat_fir", int'(FIRout), 255);
        check("sat_root", int'(ROOTout), 255);
        for (int i = 0; i < 18; i++) step(0);
        check("drain_fir", int'(FIRout), 0);
        check("drain_root", int'(ROOTout), 0);

        // Single newest tap at full scale, then the minimum nonzero sample.
        for (int k = 0; k < 7; k++) coef[k] = k == 0 ? 8'd255 : 8'd0;
        do_reset();
        step(255);
        step(0);
        check("tap_fir_254", int'(FIRout), 254);
        for (int i = 0; i < 8; i++) step(0);
        check("tap_root_255", int'(ROOTout), 255);
        step(1);
        step(0);
        check("tap_fir_small", int'(FIRout), 0);
        for (int i = 0; i < 8; i++) step(0);
        check("tap_root_15", int'(ROOTout), 15);

        // Random stream, coefficients occasionally changed mid-stream.
        do_reset();
        for (int k = 0; k < 7; k++) coef[k] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 20; i++) begin
            if (i == 10) coef[$urandom_range(0, 6)] = 8'($urandom_range(0, 255));
            step(int'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 9; i++) step(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
